reaction_timer_core: RTL
========================

# reaction_timer_core

Millisecond timebase, delay generator and random LED selector feeding the reaction-time FSM. Produces `timer_value` (random countdown during the wait phase, elapsed milliseconds during the reaction phase) and `random_value` (target LED index), under control of that FSM's `reset`/`up`/`enable` outputs. Sits directly upstream of the FSM; `timer_value` also drives the 7-seg display path.

## Interface
- `CLKS_PER_MS`, 50000: clk cycles per millisecond tick.
- `MAX_MS`, 2047: largest representable timer value; sets `timer_value` width W = $clog2(MAX_MS).
- `LED_NUM`, 17: number of target LEDs; `random_value` width L = $clog2(LED_NUM).
- `MIN_DELAY_MS`, 500: minimum random wait.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `timer_reset` in 1: synchronous clear/load request (from FSM `reset`).
- `up` in 1: mode; 1 = delay mode (load random delay, count down), 0 = reaction mode (clear to 0, count up).
- `enable` in 1: counting enable.
- `timer_value` out W: current millisecond value, registered.
- `random_value` out L: target LED index, 0..LED_NUM-1, registered.
- `ms_tick` out 1: one-cycle pulse each counted millisecond.
- `overflow` out 1: sticky flag, up-count hit MAX_MS.

## Operation
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, steps every clk regardless of `enable`; reset seed 16'hACE1; all-zero state forced to seed next cycle.
- Prescaler: counts 0..CLKS_PER_MS-1 while `enable`=1 and `timer_reset`=0; `ms_tick`=1 on the cycle it wraps. Holds when `enable`=0. Cleared to 0 by `timer_reset`.
- Priority per cycle: `rst` > `timer_reset` > tick counting > hold.
- `timer_reset` with `up`=1: `timer_value` <= min(MIN_DELAY_MS + lfsr[9:0], MAX_MS); `random_value` <= lfsr[15:16-L], minus LED_NUM if ≥ LED_NUM (single conditional subtract, always in range since 2^L < 2·LED_NUM); `overflow` cleared.
- `timer_reset` with `up`=0: `timer_value` <= 0; `overflow` cleared; `random_value` held.
- Tick, `up`=1: `timer_value` decrements; at 0 it stays 0 (no underflow).
- Tick, `up`=0: `timer_value` increments; at MAX_MS behaviour per Configuration.
- `random_value` changes only on a delay-mode `timer_reset`; stable through the reaction phase.
- Mode change on `up` without `timer_reset`: direction switches at next tick; value untouched.

## Timing
- Reset values: `timer_value`=0, `random_value`=0, `ms_tick`=0, `overflow`=0, prescaler=0, LFSR=16'hACE1.
- `timer_reset` effects visible on outputs the following clk edge (1-cycle latency).
- First tick after `timer_reset` deasserts with `enable`=1: exactly CLKS_PER_MS cycles later; `timer_value` updates the edge after `ms_tick` is sampled high (registered together, same edge).
- `rst` mid-count: all state returns to reset values immediately, asynchronously.
- `timer_reset` held multiple cycles: reload repeats each cycle (new LFSR sample each cycle in delay mode); counting resumes after final deassertion.
- `timer_reset` and tick in same cycle: reload wins, tick discarded.

## Configuration
- `REACTION_TIMER_SATURATE_EN` defined: up-count stops at MAX_MS; on the tick that would exceed it, value holds MAX_MS and `overflow` sets (sticky until `timer_reset` or `rst`).
- Not defined: up-count wraps MAX_MS -> 0; `overflow` tied 0.

## Test plan
- CLKS_PER_MS=4, `rst` pulse -> all outputs 0, LFSR=16'hACE1; release, `enable`=0 for 20 cycles -> `timer_value` stays 0, no `ms_tick`.
- `up`=1, `timer_reset` 1 cycle, then `enable`=1 -> `timer_value` in [500,1523] next edge, `random_value` <17, decrements by 1 every 4 cycles, halts at 0.
- `up`=0, `timer_reset` 1 cycle, `enable`=1 for 40 cycles -> `timer_value`=10, 10 `ms_tick` pulses; `enable`=0 mid-count -> value and prescaler freeze, resume without lost cycles.
- MAX_MS=15, up-count 20 ticks -> SATURATE_EN: holds 15, `overflow`=1 until next `timer_reset`; without: wraps to 4, `overflow`=0.
- 1000 delay-mode reloads -> every `random_value` in 0..16, every load in [500,1523], LFSR never zero.
- `timer_reset` coincident with tick, and `rst` asserted mid-count -> reload wins / all outputs 0 asynchronously.

Source files
------------

// File: rtl/reaction_timer_core.sv
// reaction_timer_core: millisecond prescaler, random-delay / reaction-time counter and random LED picker.
// Define REACTION_TIMER_SATURATE_EN to saturate the up-count at MAX_MS with a sticky overflow flag.
module reaction_timer_core #(
  parameter int CLKS_PER_MS  = 50000,
  parameter int MAX_MS       = 2047,
  parameter int LED_NUM      = 17,
  parameter int MIN_DELAY_MS = 500,
  localparam int W = $clog2(MAX_MS),
  localparam int L = $clog2(LED_NUM)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         timer_reset,
  input  logic         up,
  input  logic         enable,
  output logic [W-1:0] timer_value,
  output logic [L-1:0] random_value,
  output logic         ms_tick,
  output logic         overflow
);

  localparam int              PW         = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [15:0]     LFSR_SEED  = 16'hACE1;
  localparam logic [15:0]     LFSR_TAPS  = 16'hB400;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(CLKS_PER_MS - 1);
  localparam logic [W-1:0]    TV_MAX     = W'(MAX_MS);

  logic [15:0]   lfsr;
  logic [PW-1:0] presc;
  logic          presc_wrap;
  logic          at_max;
  logic [W-1:0]  tv_count;

  // Galois step for x^16+x^14+x^13+x^11+1; a stuck all-zero state is kicked back to the seed.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    if (s == 16'h0000) return LFSR_SEED;
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  function automatic logic [W-1:0] delay_load(input logic [9:0] r);
    logic [31:0] d;
    d = 32'(MIN_DELAY_MS) + 32'(r);
    if (d > 32'(MAX_MS)) d = 32'(MAX_MS);
    return W'(d);
  endfunction

  // One conditional subtract suffices because 2^L < 2*LED_NUM.
  function automatic logic [L-1:0] led_pick(input logic [L-1:0] r);
    if (32'(r) >= LED_NUM) return r - L'(LED_NUM);
    return r;
  endfunction

  always_comb begin
    presc_wrap = enable && !timer_reset && (presc == PRESC_LAST);
    at_max     = (timer_value == TV_MAX);
    tv_count   = timer_value;
    if (up) begin
      if (timer_value != '0) tv_count = timer_value - W'(1);
    end else if (!at_max) begin
      tv_count = timer_value + W'(1);
    end else begin
`ifdef REACTION_TIMER_SATURATE_EN
      tv_count = TV_MAX;
`else
      tv_count = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr         <= LFSR_SEED;
      presc        <= '0;
      ms_tick      <= 1'b0;
      timer_value  <= '0;
      random_value <= '0;
    end else begin
      lfsr    <= lfsr_next(lfsr);
      ms_tick <= presc_wrap;
      if (timer_reset) begin
        presc <= '0;
        if (up) begin
          timer_value  <= delay_load(lfsr[9:0]);
          random_value <= led_pick(lfsr[15 -: L]);
        end else begin
          timer_value <= '0;
        end
      end else if (enable) begin
        if (presc_wrap) begin
          presc       <= '0;
          timer_value <= tv_count;
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

`ifdef REACTION_TIMER_SATURATE_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (timer_reset) begin
      ovf_q <= 1'b0;
    end else if (presc_wrap && !up && at_max) begin
      ovf_q <= 1'b1;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule
